des_key_sched_ctrl: RTL and testbench

- Iterative DES key-schedule sequencer for the round engine, replacing the fully unrolled 16-key generator.
- Accepts one 64-bit key and mode over a valid/ready handshake, then streams one 48-bit round key per accepted cycle.
- Round keys come out in encryption order (K1..K16) or decryption order (K16..K1).
- Holds one C/D register pair, supports downstream back-pressure, and signals completion to the round-engine controller.

---
 rtl/des_pkg.sv | 58 +++++
 rtl/des_key_sched_ctrl_if.sv | 32 +++
 rtl/des_pc2_perm.sv | 26 ++
 rtl/des_key_sched_ctrl.sv | 159 +++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | des_pkg                                                            |
// | DES key-schedule constants: PC1/PC2 tables, shift counts, states.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 28;
    localparam int PC1_W = 56;
    localparam int RK_W  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Entries are 1-based DES bit numbers; DES bit 1 is the MSB of the vector.
    localparam int PC1_TAB [PC1_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Index 0 holds the shift for round 1.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_sched_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | des_key_sched_ctrl_if                                              |
// | Key-in and round-key-out handshake bundle for the key scheduler.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface des_key_sched_ctrl_if;
    import des_pkg::*;

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key;
    logic             decrypt;
    logic             abort;
    logic             rk_valid;
    logic             rk_ready;
    logic [RK_W-1:0]  rk;
    logic [3:0]       rk_round;
    logic             done;
    logic             parity_err;

    modport master (
        output key_valid, key, decrypt, abort, rk_ready,
        input  key_ready, rk_valid, rk, rk_round, done, parity_err
    );

    modport slave (
        input  key_valid, key, decrypt, abort, rk_ready,
        output key_ready, rk_valid, rk, rk_round, done, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/des_pc2_perm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | des_pc2_perm                                                       |
// | Combinational DES PC2 permutation, {C,D} 56 bits -> 48-bit key.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module des_pc2_perm
    import des_pkg::*;
(
    input  wire logic [PC1_W-1:0] i_cd,
    output logic      [RK_W-1:0]  o_rk
);

    generate
        for (genvar i = 0; i < RK_W; i++) begin : g_pc2
            assign o_rk[RK_W-1-i] = i_cd[PC1_W - PC2_TAB[i]];
        end
    endgenerate

    // PC2 drops DES bits 9,18,22,25,35,38,43,54 of the 56-bit {C,D}.
    logic w_unused_dropped;
    assign w_unused_dropped = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                                i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

endmodule
`default_nettype wire

// File: rtl/des_key_sched_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | des_key_sched_ctrl                                                 |
// | Iterative DES key schedule: one C/D pair, 48-bit key per handshake.|
// | Optional key parity check: define DES_KEY_PARITY_CHK_EN.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module des_key_sched_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
)(
    input  wire logic           clk,
    input  wire logic           rst_n,
    des_key_sched_ctrl_if.slave bus
);

    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_e            state_q, state_d;
    logic [CD_W-1:0]   c_q, c_d, d_q, d_d;
    logic              dec_q, dec_d;
    logic              key_ready_q, key_ready_d;
    logic              rk_valid_q, rk_valid_d;
    logic              done_q, done_d;
    logic [3:0]        rk_round_q, rk_round_d;
    logic [RK_W-1:0]   rk_q, rk_d;
    logic [PC1_W-1:0]  w_pc1;
    logic [3:0]        w_enc_idx, w_dec_idx;

    generate
        for (genvar i = 0; i < PC1_W; i++) begin : g_pc1
            assign w_pc1[PC1_W-1-i] = bus.key[KEY_W - PC1_TAB[i]];
        end
    endgenerate

    // Shift for the next round: encrypt walks forward, decrypt undoes from the end.
    assign w_enc_idx = rk_round_q + 4'd1;
    assign w_dec_idx = 4'd15 - rk_round_q;

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        d_d         = d_q;
        dec_d       = dec_q;
        key_ready_d = key_ready_q;
        rk_valid_d  = rk_valid_q;
        rk_round_d  = rk_round_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_valid && !bus.abort) begin
                    dec_d       = bus.decrypt;
                    c_d         = bus.decrypt ? w_pc1[PC1_W-1:CD_W] : rotl28(w_pc1[PC1_W-1:CD_W], SHIFT_TAB[0]);
                    d_d         = bus.decrypt ? w_pc1[CD_W-1:0]     : rotl28(w_pc1[CD_W-1:0], SHIFT_TAB[0]);
                    rk_round_d  = 4'd0;
                    rk_valid_d  = 1'b1;
                    key_ready_d = 1'b0;
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                if (bus.abort) begin
                    rk_valid_d  = 1'b0;
                    key_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (bus.rk_ready) begin
                    if (rk_round_q == C_LAST_ROUND) begin
                        rk_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        rk_round_d = rk_round_q + 4'd1;
                        c_d = dec_q ? rotr28(c_q, SHIFT_TAB[w_dec_idx]) : rotl28(c_q, SHIFT_TAB[w_enc_idx]);
                        d_d = dec_q ? rotr28(d_q, SHIFT_TAB[w_dec_idx]) : rotl28(d_q, SHIFT_TAB[w_enc_idx]);
                    end
                end
            end
            DONE: begin
                key_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                rk_valid_d  = 1'b0;
                key_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // rk always tracks PC2 of the next C/D, so it only moves when C/D move.
    des_pc2_perm u_pc2 (
        .i_cd ({c_d, d_d}),
        .o_rk (rk_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            d_q         <= '0;
            dec_q       <= 1'b0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_round_q  <= 4'd0;
            done_q      <= 1'b0;
            rk_q        <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            d_q         <= d_d;
            dec_q       <= dec_d;
            key_ready_q <= key_ready_d;
            rk_valid_q  <= rk_valid_d;
            rk_round_q  <= rk_round_d;
            done_q      <= done_d;
            rk_q        <= rk_d;
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk        = rk_q;
    assign bus.rk_round  = rk_round_q;
    assign bus.done      = done_q;

`ifdef DES_KEY_PARITY_CHK_EN
    logic [7:0] w_byte_even;
    logic       w_accept;
    logic       parity_err_q, parity_err_d;

    generate
        for (genvar b = 0; b < 8; b++) begin : g_par
            assign w_byte_even[b] = ~^bus.key[8*b +: 8];
        end
    endgenerate

    assign w_accept = (state_q == IDLE) && bus.key_valid && !bus.abort;

    always_comb begin
        parity_err_d = parity_err_q;
        if (w_accept) parity_err_d = |w_byte_even;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign bus.parity_err = parity_err_q;
`else
    logic w_unused_key_parity;
    assign w_unused_key_parity = ^{bus.key[56], bus.key[48], bus.key[40], bus.key[32],
                                   bus.key[24], bus.key[16], bus.key[8],  bus.key[0]};
    assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_des_key_sched_ctrl                                              |
// | Directed bench for des_key_sched_ctrl using known DES round keys.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_des_key_sched_ctrl;

    localparam logic [63:0] C_KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] C_KEY_BAD  = 64'h123457799BBCDFF1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_key_sched_ctrl_if bus();

    des_key_sched_ctrl #(.NUM_ROUNDS(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_k [16];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_key_ready"},  64'(bus.key_ready),  64'd1);
        check_val({tag, "_rk_valid"},   64'(bus.rk_valid),   64'd0);
        check_val({tag, "_rk"},         64'(bus.rk),         64'd0);
        check_val({tag, "_rk_round"},   64'(bus.rk_round),   64'd0);
        check_val({tag, "_done"},       64'(bus.done),       64'd0);
        check_val({tag, "_parity_err"}, 64'(bus.parity_err), 64'd0);
    endtask

    // Runs one schedule; stall_pct>0 randomises rk_ready, abort_at>=0 aborts at that round.
    task automatic run_sched(input logic [63:0] k, input logic dec, input int stall_pct,
                             input bit chk_vals, input int abort_at);
        int idx, cyc, done_cyc;
        bit stalled, rdy;
        logic [47:0] prev_rk, exp;
        logic [3:0]  prev_round;
        idx = 0; cyc = 1; done_cyc = -1; stalled = 0;
        prev_rk = '0; prev_round = '0;
        check_val("idle_key_ready", 64'(bus.key_ready), 64'd1);
        bus.key = k; bus.decrypt = dec; bus.key_valid = 1'b1; bus.rk_ready = 1'b0;
        @(posedge clk); #1;
        bus.key_valid = 1'b0; bus.key = ~k; bus.decrypt = ~dec;
        while (cyc < 200) begin
            if (stalled) begin
                check_val("stall_rk", 64'(bus.rk), 64'(prev_rk));
                check_val("stall_round", 64'(bus.rk_round), 64'(prev_round));
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (idx < 16) check_val("rk_valid", 64'(bus.rk_valid), 64'd1);
            if (abort_at >= 0 && bus.rk_valid && int'(bus.rk_round) == abort_at) begin
                bus.abort = 1'b1; bus.rk_ready = 1'b1;
                @(posedge clk); #1;
                bus.abort = 1'b0; bus.rk_ready = 1'b0;
                check_val("abort_rk_valid", 64'(bus.rk_valid), 64'd0);
                check_val("abort_key_ready", 64'(bus.key_ready), 64'd1);
                check_val("abort_done", 64'(bus.done), 64'd0);
                @(posedge clk); #1;
                check_val("abort_done_later", 64'(bus.done), 64'd0);
                check_val("abort_handshakes", 64'(idx), 64'(abort_at));
                return;
            end
            rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= 32'(stall_pct));
            bus.rk_ready = rdy;
            if (bus.rk_valid && rdy) begin
                exp = dec ? exp_k[15-idx] : exp_k[idx];
                if (chk_vals) check_val($sformatf("rk[%0d]", idx), 64'(bus.rk), 64'(exp));
                check_val("rk_round", 64'(bus.rk_round), 64'(idx));
                idx++;
                stalled = 0;
            end else begin
                stalled = bus.rk_valid;
                prev_rk = bus.rk;
                prev_round = bus.rk_round;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.rk_ready = 1'b0;
        check_val("handshakes", 64'(idx), 64'd16);
        if (stall_pct == 0) check_val("done_latency", 64'(done_cyc), 64'd17);
        else                check_val("done_seen", 64'(done_cyc > 0), 64'd1);
        check_val("done_rk_valid", 64'(bus.rk_valid), 64'd0);
        @(posedge clk); #1;
        check_val("done_pulse_end", 64'(bus.done), 64'd0);
        check_val("ready_after_done", 64'(bus.key_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal;
    end

    initial begin
        exp_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                  48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                  48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                  48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        rst_n = 1'b0;
        bus.key_valid = 1'b0; bus.key = '0; bus.decrypt = 1'b0;
        bus.abort = 1'b0; bus.rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sched(C_KEY_GOOD, 1'b0, 0,  1'b1, -1);
        run_sched(C_KEY_GOOD, 1'b1, 0,  1'b1, -1);
        run_sched(C_KEY_GOOD, 1'b0, 50, 1'b1, -1);
        run_sched(C_KEY_GOOD, 1'b1, 50, 1'b1, -1);
        run_sched(C_KEY_GOOD, 1'b0, 0,  1'b1, 7);
        run_sched(C_KEY_GOOD, 1'b0, 0,  1'b1, -1);

        // Reset in the middle of a decrypt schedule.
        bus.key = C_KEY_GOOD; bus.decrypt = 1'b1; bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0; bus.rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; bus.rk_ready = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;

        // Abort together with key_valid in IDLE must not start a schedule.
        bus.key = C_KEY_GOOD; bus.decrypt = 1'b0; bus.key_valid = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0; bus.abort = 1'b0;
        check_val("abort_kv_key_ready", 64'(bus.key_ready), 64'd1);
        check_val("abort_kv_rk_valid", 64'(bus.rk_valid), 64'd0);
        @(posedge clk); #1;
        check_val("abort_kv_still_idle", 64'(bus.rk_valid), 64'd0);

`ifdef DES_KEY_PARITY_CHK_EN
        run_sched(C_KEY_GOOD, 1'b0, 0, 1'b1, -1);
        check_val("parity_good", 64'(bus.parity_err), 64'd0);
        run_sched(C_KEY_BAD, 1'b0, 0, 1'b0, -1);
        check_val("parity_bad", 64'(bus.parity_err), 64'd1);
`else
        run_sched(C_KEY_BAD, 1'b0, 0, 1'b0, -1);
        check_val("parity_tied_low", 64'(bus.parity_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
